multi_mole_spawner: RTL and testbench

//  Parametrised successor to the single-LED mole timer/FSM pair. Runs NUM_MOLES independent

---
 rtl/multi_mole_spawner.sv | 203 ++++++++++++++++++++
 tb/tb_multi_mole_spawner.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mole_spawner.sv
// -----------------------------------------------------------------------------
// multi_mole_spawner
//
// Runs NUM_MOLES independent mole channels off one shared 16-bit Galois LFSR
// and a 1 ms tick. Each channel cycles WAIT -> UP -> COOL. The random spawn
// delay and the visible time both shrink with the difficulty level. At most
// MAX_ACTIVE channels can be UP at once.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset (released synchronously upstream)
//   enable        game running; low parks every channel in WAIT and silences outputs
//   ms_tick       one-clk pulse every millisecond
//   level         difficulty level 0..3, sampled at each counter load
//   whack         one-clk pulse per hole
//   mole_up       channel i is UP (drives the LEDs)
//   hit_pulse     one-clk pulse: mole i whacked while UP
//   miss_pulse    one-clk pulse: mole i expired without being whacked
//   bad_whack     one-clk pulse: whack[i] while channel i is not UP
//   active_count  number of channels currently UP (popcount of mole_up)
// -----------------------------------------------------------------------------
module multi_mole_spawner #(
    parameter int          NUM_MOLES    = 4,
    parameter int          MAX_MS       = 2047,
    parameter int          MIN_DELAY_MS = 200,
    parameter int          UP_TIME_MS   = 1600,
    parameter int          COOL_MS      = 100,
    parameter int          MAX_ACTIVE   = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           ms_tick,
    input  logic [1:0]                     level,
    input  logic [NUM_MOLES-1:0]           whack,
    output logic [NUM_MOLES-1:0]           mole_up,
    output logic [NUM_MOLES-1:0]           hit_pulse,
    output logic [NUM_MOLES-1:0]           miss_pulse,
    output logic [NUM_MOLES-1:0]           bad_whack,
    output logic [$clog2(NUM_MOLES+1)-1:0] active_count
);

    localparam int TW = $clog2(MAX_MS + 1);
    localparam int CW = $clog2(NUM_MOLES + 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_UP,
        S_COOL
    } state_t;

    state_t               r_state [NUM_MOLES];
    logic [TW-1:0]        r_cnt   [NUM_MOLES];
    logic [15:0]          r_lfsr;

    logic [15:0]          w_lfsr_next;
    logic [NUM_MOLES-1:0] w_req;
    logic [NUM_MOLES-1:0] w_grant;
    logic [NUM_MOLES-1:0] w_stay_up;
    logic [NUM_MOLES-1:0] w_next_up;
    logic [CW-1:0]        w_next_count;

    // Rotate left so each channel sees a different slice of the shared LFSR.
    function automatic logic [15:0] rotl16(input logic [15:0] v, input int sh);
        int s;
        s = sh % 16;
        if (s == 0) return v;
        return (v << s) | (v >> (16 - s));
    endfunction

    // WAIT reload: minimum delay plus a random part scaled down by the level,
    // saturated at the counter range.
    function automatic logic [TW-1:0] wait_load(input logic [15:0] lfsr,
                                                input int          idx,
                                                input logic [1:0]  lvl);
        logic [15:0]   rot;
        logic [TW-1:0] rnd;
        int            sum;
        rot = rotl16(lfsr, 3 * idx);
        rnd = rot[TW-1:0] >> lvl;
        sum = MIN_DELAY_MS + int'(rnd);
        if (sum > MAX_MS) sum = MAX_MS;
        return TW'(sum);
    endfunction

    // UP reload: never zero, otherwise the expiry compare at cnt==1 is missed.
    function automatic logic [TW-1:0] up_load(input logic [1:0] lvl);
        int u;
        u = UP_TIME_MS >> lvl;
        if (u < 1) u = 1;
        return TW'(u);
    endfunction

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // NOTE: every combinational output gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_req     = '0;
        w_stay_up = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            w_req[i]     = enable && ms_tick && (r_state[i] == S_WAIT) && (r_cnt[i] == '0);
            w_stay_up[i] = enable && (r_state[i] == S_UP) && !whack[i]
                           && !(ms_tick && (r_cnt[i] == TW'(1)));
        end
    end

    // Free slots are judged on the count at the start of this cycle, so a slot
    // released now is only reusable on a later tick.
    always_comb begin
        int slots;
        w_grant = '0;
        slots   = MAX_ACTIVE - int'(active_count);
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (w_req[i] && (slots > 0)) begin
                w_grant[i] = 1'b1;
                slots      = slots - 1;
            end
        end
    end

    always_comb begin
        w_next_up    = w_stay_up | w_grant;
        w_next_count = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            w_next_count = w_next_count + CW'(w_next_up[i]);
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // in this block updates from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr       <= LFSR_SEED;
            mole_up      <= '0;
            hit_pulse    <= '0;
            miss_pulse   <= '0;
            bad_whack    <= '0;
            active_count <= '0;
            // NOTE: the per-channel arrays are real state registers with a
            // defined start value, so they are reset element by element.
            for (int i = 0; i < NUM_MOLES; i++) begin
                r_state[i] <= S_WAIT;
                r_cnt[i]   <= TW'(MIN_DELAY_MS + i);
            end
        end else begin
            r_lfsr       <= w_lfsr_next;
            mole_up      <= w_next_up;
            active_count <= w_next_count;
            hit_pulse    <= '0;
            miss_pulse   <= '0;
            bad_whack    <= '0;
            for (int i = 0; i < NUM_MOLES; i++) begin
                if (!enable) begin
                    r_state[i] <= S_WAIT;
                    r_cnt[i]   <= wait_load(r_lfsr, i, level);
                end else begin
                    case (r_state[i])
                        S_WAIT: begin
                            bad_whack[i] <= whack[i];
                            if (w_grant[i]) begin
                                r_state[i] <= S_UP;
                                r_cnt[i]   <= up_load(level);
                            end else if (ms_tick && (r_cnt[i] != '0)) begin
                                r_cnt[i] <= r_cnt[i] - TW'(1);
                            end
                        end
                        S_UP: begin
                            // A whack on the expiry tick counts as a hit.
                            if (whack[i]) begin
                                hit_pulse[i] <= 1'b1;
                                r_state[i]   <= S_COOL;
                                r_cnt[i]     <= TW'(COOL_MS);
                            end else if (ms_tick && (r_cnt[i] == TW'(1))) begin
                                miss_pulse[i] <= 1'b1;
                                r_state[i]    <= S_COOL;
                                r_cnt[i]      <= TW'(COOL_MS);
                            end else if (ms_tick) begin
                                r_cnt[i] <= r_cnt[i] - TW'(1);
                            end
                        end
                        S_COOL: begin
                            bad_whack[i] <= whack[i];
                            if (ms_tick && (r_cnt[i] == '0)) begin
                                r_state[i] <= S_WAIT;
                                r_cnt[i]   <= wait_load(r_lfsr, i, level);
                            end else if (ms_tick) begin
                                r_cnt[i] <= r_cnt[i] - TW'(1);
                            end
                        end
                        default: begin
                            r_state[i] <= S_WAIT;
                            r_cnt[i]   <= wait_load(r_lfsr, i, level);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_mole_spawner.sv
`timescale 1ns/1ps
// Directed bench for multi_mole_spawner with default parameters
// (4 moles, MAX_ACTIVE 2, 200 ms minimum delay, 1600 ms visible time).
module tb_multi_mole_spawner;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       ms_tick;
    logic [1:0] level;
    logic [3:0] whack;
    logic [3:0] mole_up;
    logic [3:0] hit_pulse;
    logic [3:0] miss_pulse;
    logic [3:0] bad_whack;
    logic [2:0] active_count;

    int n_tests = 0;
    int n_fail  = 0;

    multi_mole_spawner dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ms_tick      (ms_tick),
        .level        (level),
        .whack        (whack),
        .mole_up      (mole_up),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .bad_whack    (bad_whack),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    // One clock with the given tick/whack values; outputs are read 1 ns after the edge.
    task automatic step(input logic tk, input logic [3:0] wh);
        ms_tick = tk;
        whack   = wh;
        @(posedge clk);
        #1;
        ms_tick = 1'b0;
        whack   = 4'b0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        level   = 2'd0;
        ms_tick = 1'b0;
        whack   = 4'b0000;
        #1;
        n_tests++;
        if ({mole_up, hit_pulse, miss_pulse, bad_whack, active_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%0d expected all zero",
                     mole_up, hit_pulse, miss_pulse, bad_whack, active_count);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (mole_up !== 4'b0000 || active_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: mole_up=%b count=%0d expected 0000/0", mole_up, active_count);
        end
    endtask

    // Level 0, tick every 4 clk: ch0 up on tick 201, ch1 on 202, ch2/ch3 held by the cap.
    task automatic test_spawn_and_miss();
        int up0;
        int stray;
        up0   = 0;
        stray = 0;
        @(posedge clk);
        #1;
        for (int t = 1; t <= 1800; t++) begin
            step(1'b1, 4'b0000);
            if (mole_up[0]) up0++;
            if ((hit_pulse | miss_pulse | bad_whack) != 4'b0000) stray++;
            if (t == 200) begin
                n_tests++;
                if (mole_up !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL spawn_tick200: mole_up=%b expected 0000", mole_up);
                end
            end
            if (t == 201) begin
                n_tests++;
                if (mole_up !== 4'b0001 || active_count !== 3'd1) begin
                    n_fail++;
                    $display("FAIL spawn_tick201: mole_up=%b count=%0d expected 0001/1", mole_up, active_count);
                end
            end
            if (t == 202) begin
                n_tests++;
                if (mole_up !== 4'b0011 || active_count !== 3'd2) begin
                    n_fail++;
                    $display("FAIL spawn_tick202: mole_up=%b count=%0d expected 0011/2", mole_up, active_count);
                end
            end
            if (t == 204) begin
                n_tests++;
                if (mole_up !== 4'b0011 || active_count !== 3'd2) begin
                    n_fail++;
                    $display("FAIL cap_tick204: mole_up=%b count=%0d expected 0011/2", mole_up, active_count);
                end
            end
            repeat (3) step(1'b0, 4'b0000);
        end
        n_tests++;
        if (up0 !== 1600) begin
            n_fail++;
            $display("FAIL up_duration: ch0 up for %0d ticks expected 1600", up0);
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL stray_pulses: %0d pulse samples expected 0", stray);
        end
        // Tick 1801: ch0 expires; count was still 2 so ch2 stays denied.
        step(1'b1, 4'b0000);
        n_tests++;
        if (miss_pulse !== 4'b0001 || mole_up !== 4'b0010 || active_count !== 3'd1) begin
            n_fail++;
            $display("FAIL miss_ch0: miss=%b up=%b count=%0d expected 0001/0010/1",
                     miss_pulse, mole_up, active_count);
        end
        step(1'b0, 4'b0000);
        n_tests++;
        if (miss_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL miss_width: miss=%b expected 0000", miss_pulse);
        end
        repeat (2) step(1'b0, 4'b0000);
        // Tick 1802: ch1 expires, ch2 takes the free slot.
        step(1'b1, 4'b0000);
        n_tests++;
        if (miss_pulse !== 4'b0010 || mole_up !== 4'b0100) begin
            n_fail++;
            $display("FAIL miss_ch1_grant_ch2: miss=%b up=%b expected 0010/0100", miss_pulse, mole_up);
        end
        repeat (3) step(1'b0, 4'b0000);
        // Tick 1803: ch3 takes the remaining slot.
        step(1'b1, 4'b0000);
        n_tests++;
        if (mole_up !== 4'b1100 || active_count !== 3'd2 || miss_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL grant_ch3: up=%b count=%0d miss=%b expected 1100/2/0000",
                     mole_up, active_count, miss_pulse);
        end
    endtask

    task automatic test_cool_bad_whack();
        step(1'b0, 4'b0001);
        n_tests++;
        if (bad_whack !== 4'b0001 || mole_up !== 4'b1100 || hit_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL cool_bad_whack: bad=%b up=%b hit=%b expected 0001/1100/0000",
                     bad_whack, mole_up, hit_pulse);
        end
        step(1'b0, 4'b0000);
        n_tests++;
        if (bad_whack !== 4'b0000) begin
            n_fail++;
            $display("FAIL bad_whack_width: bad=%b expected 0000", bad_whack);
        end
    endtask

    task automatic test_enable_drop();
        int first;
        int stray;
        enable = 1'b0;
        step(1'b0, 4'b1111);
        n_tests++;
        if ({mole_up, hit_pulse, miss_pulse, bad_whack, active_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL enable_drop: up=%b hit=%b miss=%b bad=%b count=%0d expected all zero",
                     mole_up, hit_pulse, miss_pulse, bad_whack, active_count);
        end
        step(1'b1, 4'b1100);
        n_tests++;
        if ({mole_up, hit_pulse, miss_pulse, bad_whack} !== 16'd0) begin
            n_fail++;
            $display("FAIL disabled_quiet: up=%b hit=%b miss=%b bad=%b expected all zero",
                     mole_up, hit_pulse, miss_pulse, bad_whack);
        end
        enable = 1'b1;
        first  = 0;
        stray  = 0;
        for (int t = 1; t <= 2100 && first == 0; t++) begin
            step(1'b1, 4'b0000);
            if ((hit_pulse | miss_pulse | bad_whack) != 4'b0000) stray++;
            if (mole_up != 4'b0000) first = t;
        end
        n_tests++;
        if (first < 201 || first > 2048) begin
            n_fail++;
            $display("FAIL reenable_delay: first mole up at tick %0d expected 201..2048", first);
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL reenable_stray: %0d pulse samples expected 0", stray);
        end
    endtask

    // Called right after a mole has risen, so a channel is UP here.
    task automatic test_reset_mid_up();
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({mole_up, hit_pulse, miss_pulse, bad_whack, active_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: up=%b hit=%b miss=%b bad=%b count=%0d expected all zero",
                     mole_up, hit_pulse, miss_pulse, bad_whack, active_count);
        end
        repeat (3) step(1'b1, 4'b0000);
        n_tests++;
        if (miss_pulse !== 4'b0000 || mole_up !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: miss=%b up=%b expected 0000/0000", miss_pulse, mole_up);
        end
        level = 2'd3;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (dut.r_lfsr !== 16'hACE1) begin
            n_fail++;
            $display("FAIL lfsr_seed: lfsr=%h expected ace1", dut.r_lfsr);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (dut.r_lfsr !== 16'hE270) begin
            n_fail++;
            $display("FAIL lfsr_step1: lfsr=%h expected e270", dut.r_lfsr);
        end
        step(1'b0, 4'b0000);
        n_tests++;
        if (dut.r_lfsr !== 16'h7138) begin
            n_fail++;
            $display("FAIL lfsr_step2: lfsr=%h expected 7138", dut.r_lfsr);
        end
    endtask

    // Fresh reset: ch2 starts at 202, five ticks leave 197.
    task automatic test_wait_bad_whack();
        repeat (5) step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        n_tests++;
        if (bad_whack !== 4'b0100 || mole_up !== 4'b0000) begin
            n_fail++;
            $display("FAIL wait_bad_whack: bad=%b up=%b expected 0100/0000", bad_whack, mole_up);
        end
        n_tests++;
        if (dut.r_cnt[2] !== 11'd197) begin
            n_fail++;
            $display("FAIL wait_cnt_kept: cnt=%0d expected 197", dut.r_cnt[2]);
        end
        step(1'b0, 4'b0000);
        n_tests++;
        if (bad_whack !== 4'b0000) begin
            n_fail++;
            $display("FAIL wait_bad_width: bad=%b expected 0000", bad_whack);
        end
    endtask

    // Level 3, tick every clk: visible time 200 ticks.
    task automatic test_hit();
        for (int t = 6; t <= 212; t++) begin
            step(1'b1, 4'b0000);
            if (t == 201) begin
                n_tests++;
                if (mole_up !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL l3_tick201: up=%b expected 0001", mole_up);
                end
            end
            if (t == 202) begin
                n_tests++;
                if (mole_up !== 4'b0011 || active_count !== 3'd2) begin
                    n_fail++;
                    $display("FAIL l3_tick202: up=%b count=%0d expected 0011/2", mole_up, active_count);
                end
            end
        end
        step(1'b0, 4'b0010);
        n_tests++;
        if (hit_pulse !== 4'b0010 || mole_up !== 4'b0001 || miss_pulse !== 4'b0000 || bad_whack !== 4'b0000) begin
            n_fail++;
            $display("FAIL hit_ch1: hit=%b up=%b miss=%b bad=%b expected 0010/0001/0000/0000",
                     hit_pulse, mole_up, miss_pulse, bad_whack);
        end
        step(1'b0, 4'b0000);
        n_tests++;
        if (hit_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL hit_width: hit=%b expected 0000", hit_pulse);
        end
        step(1'b1, 4'b0000);
        n_tests++;
        if (mole_up !== 4'b0101 || active_count !== 3'd2) begin
            n_fail++;
            $display("FAIL grant_after_hit: up=%b count=%0d expected 0101/2", mole_up, active_count);
        end
    endtask

    // ch0 loaded 200 at tick 201, so tick 401 is its expiry tick.
    task automatic test_hit_on_expiry();
        int stray;
        stray = 0;
        for (int t = 214; t <= 400; t++) begin
            step(1'b1, 4'b0000);
            if ((hit_pulse | miss_pulse | bad_whack) != 4'b0000) stray++;
        end
        n_tests++;
        if (stray !== 0 || mole_up !== 4'b0101) begin
            n_fail++;
            $display("FAIL before_expiry: stray=%0d up=%b expected 0/0101", stray, mole_up);
        end
        step(1'b1, 4'b0001);
        n_tests++;
        if (hit_pulse !== 4'b0001 || miss_pulse !== 4'b0000 || mole_up !== 4'b0100) begin
            n_fail++;
            $display("FAIL hit_on_expiry: hit=%b miss=%b up=%b expected 0001/0000/0100",
                     hit_pulse, miss_pulse, mole_up);
        end
        step(1'b1, 4'b0000);
        n_tests++;
        if (mole_up !== 4'b1100 || hit_pulse !== 4'b0000 || miss_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_expiry: up=%b hit=%b miss=%b expected 1100/0000/0000",
                     mole_up, hit_pulse, miss_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_and_miss();
        test_cool_bad_whack();
        test_enable_drop();
        test_reset_mid_up();
        test_wait_bad_whack();
        test_hit();
        test_hit_on_expiry();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
